// File: rtl/decode_round_scheduler.sv
// Round sequencer for a decoder hub: issues round-start pulses and classifies each round
// as pass, fail or timeout. It also accumulates per-run statistics for host readout.
module decode_round_scheduler #(
  parameter int ITERATION_COUNTER_WIDTH = 8,
  parameter int RESET_THRESHOLD         = 100,
  parameter int INTER_ROUND_GAP         = 4,
  parameter int TIMEOUT_CYCLES          = 4096,
  parameter int MAX_ITERATIONS          = 255
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               enable,
  input  logic [31:0]                        num_tests,
  input  logic                               result_valid,
  input  logic                               deadlock,
  input  logic [ITERATION_COUNTER_WIDTH-1:0] iteration_counter,
  output logic                               new_round_start,
  output logic                               busy,
  output logic                               done,
  output logic [31:0]                        test_case,
  output logic [31:0]                        cycle_counter,
  output logic [31:0]                        last_cycles,
  output logic [1:0]                         last_status,
  output logic [31:0]                        pass_count,
  output logic [31:0]                        fail_count,
  output logic [31:0]                        timeout_count,
  output logic [2:0]                         state_o
);

  typedef enum logic [2:0] {
    S_WARMUP = 3'd0,
    S_IDLE   = 3'd1,
    S_START  = 3'd2,
    S_WAIT   = 3'd3,
    S_RECORD = 3'd4,
    S_GAP    = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  localparam logic [1:0] ST_NONE    = 2'd0;
  localparam logic [1:0] ST_PASS    = 2'd1;
  localparam logic [1:0] ST_FAIL    = 2'd2;
  localparam logic [1:0] ST_TIMEOUT = 2'd3;

  state_t      state_q, state_d;
  logic [31:0] warm_q;
  logic [31:0] gap_q;
  logic [31:0] num_q;
  logic [31:0] test_case_q;
  logic [31:0] cycle_q;
  logic [31:0] last_cycles_q;
  logic [1:0]  last_status_q;
  logic [1:0]  outcome_q;
  logic [31:0] pass_q;
  logic [31:0] fail_q;
  logic [31:0] timeout_q;
  logic        rv_q;
  logic        start_q;
  logic        busy_q;
  logic        done_q;

  logic        rv_edge;
  logic [31:0] iter_ext;
  logic [1:0]  outcome;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Round protocol: new_round_start is a one-cycle pulse. The hub answers with a rising
  // edge on result_valid (a level held over from the previous round never counts) or
  // asserts deadlock. If neither arrives within TIMEOUT_CYCLES, the watchdog closes the round.
  assign rv_edge  = result_valid && !rv_q;
  assign iter_ext = 32'(iteration_counter);

  always_comb begin
    outcome = ST_NONE;
    if (deadlock)
      outcome = ST_FAIL;
    else if (rv_edge && (iter_ext > 32'(MAX_ITERATIONS)))
      outcome = ST_FAIL;
    else if (rv_edge)
      outcome = ST_PASS;
    else if (cycle_q == 32'(TIMEOUT_CYCLES - 1))
      outcome = ST_TIMEOUT;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WARMUP: if (warm_q == 32'(RESET_THRESHOLD)) state_d = S_IDLE;
      S_IDLE:   if (enable) state_d = (num_tests != 32'd0) ? S_START : S_DONE;
      S_START:  state_d = S_WAIT;
      S_WAIT:   if (outcome != ST_NONE) state_d = S_RECORD;
      S_RECORD: state_d = S_GAP;
      S_GAP: begin
        if (gap_q == 32'(INTER_ROUND_GAP - 1))
          state_d = ((test_case_q == num_q) || !enable) ? S_DONE : S_START;
      end
      S_DONE:   if (!enable) state_d = S_IDLE;
      default:  state_d = S_WARMUP;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_WARMUP;
      warm_q        <= '0;
      gap_q         <= '0;
      num_q         <= '0;
      test_case_q   <= '0;
      cycle_q       <= '0;
      last_cycles_q <= '0;
      last_status_q <= ST_NONE;
      outcome_q     <= ST_NONE;
      pass_q        <= '0;
      fail_q        <= '0;
      timeout_q     <= '0;
      rv_q          <= 1'b0;
      start_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      rv_q    <= result_valid;
      // Flag outputs are decoded from the next state so they line up with state_q.
      start_q <= (state_d == S_START);
      busy_q  <= (state_d == S_START) || (state_d == S_WAIT) ||
                 (state_d == S_RECORD) || (state_d == S_GAP);
      done_q  <= (state_d == S_DONE);

      case (state_q)
        S_WARMUP: warm_q <= sat_inc(warm_q);
        S_IDLE: begin
          if (state_d == S_START) begin
            num_q         <= num_tests;
            test_case_q   <= '0;
            pass_q        <= '0;
            fail_q        <= '0;
            timeout_q     <= '0;
            last_status_q <= ST_NONE;
          end
        end
        S_START: begin
          test_case_q <= sat_inc(test_case_q);
          cycle_q     <= '0;
        end
        S_WAIT: begin
          // Freeze the counter on the deciding cycle so it reports the round latency.
          if (outcome == ST_NONE)
            cycle_q <= sat_inc(cycle_q);
          else
            outcome_q <= outcome;
        end
        S_RECORD: begin
          last_cycles_q <= cycle_q;
          last_status_q <= outcome_q;
          gap_q         <= '0;
          case (outcome_q)
            ST_PASS: pass_q <= sat_inc(pass_q);
            ST_FAIL: fail_q <= sat_inc(fail_q);
            ST_TIMEOUT: begin
              fail_q    <= sat_inc(fail_q);
              timeout_q <= sat_inc(timeout_q);
            end
            default: ;
          endcase
        end
        S_GAP: gap_q <= sat_inc(gap_q);
        default: ;
      endcase
    end
  end

  assign new_round_start = start_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign test_case       = test_case_q;
  assign cycle_counter   = cycle_q;
  assign last_cycles     = last_cycles_q;
  assign last_status     = last_status_q;
  assign pass_count      = pass_q;
  assign fail_count      = fail_q;
  assign timeout_count   = timeout_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_decode_round_scheduler.sv
// Directed bench for decode_round_scheduler: single-round vector table plus hand-written
// multi-round sequences (latency, spacing, held result_valid, timeout, mid-round reset).
module tb_decode_round_scheduler;

  localparam int W    = 8;
  localparam int RT   = 20;
  localparam int GAP  = 4;
  localparam int TO   = 16;
  localparam int MAXI = 200;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic [31:0]   num_tests = '0;
  logic          result_valid = 1'b0;
  logic          deadlock = 1'b0;
  logic [W-1:0]  iteration_counter = '0;
  logic          new_round_start;
  logic          busy;
  logic          done;
  logic [31:0]   test_case;
  logic [31:0]   cycle_counter;
  logic [31:0]   last_cycles;
  logic [1:0]    last_status;
  logic [31:0]   pass_count;
  logic [31:0]   fail_count;
  logic [31:0]   timeout_count;
  logic [2:0]    state_o;

  int          n_vec = 0;
  int          n_err = 0;
  int unsigned cyc = 0;
  int unsigned pulse_cnt = 0;

  decode_round_scheduler #(
    .ITERATION_COUNTER_WIDTH(W),
    .RESET_THRESHOLD(RT),
    .INTER_ROUND_GAP(GAP),
    .TIMEOUT_CYCLES(TO),
    .MAX_ITERATIONS(MAXI)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .num_tests(num_tests),
    .result_valid(result_valid),
    .deadlock(deadlock),
    .iteration_counter(iteration_counter),
    .new_round_start(new_round_start),
    .busy(busy),
    .done(done),
    .test_case(test_case),
    .cycle_counter(cycle_counter),
    .last_cycles(last_cycles),
    .last_status(last_status),
    .pass_count(pass_count),
    .fail_count(fail_count),
    .timeout_count(timeout_count),
    .state_o(state_o)
  );

  // clock / cycle bookkeeping
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;
  always @(negedge clk) if (new_round_start === 1'b1) pulse_cnt = pulse_cnt + 1;

  typedef struct {
    int unsigned d;
    bit          rise;
    bit          dl;
    logic [7:0]  iter;
    logic [1:0]  st;
    logic [31:0] lc;
    logic [31:0] p;
    logic [31:0] f;
    logic [31:0] t;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic wait_start(output int unsigned at, output int unsigned n);
    at = 0;
    n  = 0;
    while (n < 400) begin
      @(negedge clk);
      n++;
      if (new_round_start === 1'b1) begin
        at = cyc;
        return;
      end
    end
    n_vec++;
    n_err++;
    $display("FAIL start_wait: no new_round_start within %0d cycles", n);
    n = 0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done === 1'b1) return;
    end
    n_vec++;
    n_err++;
    $display("FAIL done_wait: done not seen within 400 cycles");
  endtask

  // Called at the negedge where the start pulse is visible; responds d cycles later.
  task automatic drive_resp(input int unsigned d, input bit rise, input bit dl, input logic [7:0] it);
    if (!rise && !dl) return;
    repeat (d) @(negedge clk);
    iteration_counter = it;
    if (rise) result_valid = 1'b1;
    if (dl) deadlock = 1'b1;
    @(negedge clk);
    deadlock = 1'b0;
  endtask

  initial begin
    int unsigned at, n, prev, p0;

    //                d  rise dl iter  st  lc  p  f  t
    vecs[0] = '{ 1, 1'b1, 1'b0, 8'd200, 2'd1,  0, 1, 0, 0}; // iter == MAX is a pass
    vecs[1] = '{ 5, 1'b1, 1'b0, 8'd201, 2'd2,  4, 0, 1, 0}; // iter just above MAX
    vecs[2] = '{ 7, 1'b1, 1'b1, 8'd3,   2'd2,  6, 0, 1, 0}; // deadlock beats edge
    vecs[3] = '{ 3, 1'b0, 1'b1, 8'd0,   2'd2,  2, 0, 1, 0}; // deadlock alone
    vecs[4] = '{ 0, 1'b0, 1'b0, 8'd0,   2'd3, 15, 0, 1, 1}; // silent hub -> timeout
    vecs[5] = '{16, 1'b1, 1'b0, 8'd3,   2'd1, 15, 1, 0, 0}; // edge on last cycle beats timeout
    vecs[6] = '{15, 1'b1, 1'b0, 8'd255, 2'd2, 14, 0, 1, 0};
    vecs[7] = '{ 2, 1'b1, 1'b0, 8'd0,   2'd1,  1, 1, 0, 0};

    // reset values (enable already high: must be ignored until warmup ends)
    enable = 1'b1;
    num_tests = 32'd1;
    repeat (3) @(negedge clk);
    check("rst_start", {31'd0, new_round_start}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_test_case", test_case, 32'd0);
    check("rst_pass", pass_count, 32'd0);
    check("rst_status", {30'd0, last_status}, 32'd0);
    check("rst_state", {29'd0, state_o}, 32'd0);

    // first round after reset release: latency and simple pass
    reset = 1'b1;
    wait_start(at, n);
    check("first_start_latency", n, RT + 2);
    drive_resp(10, 1'b1, 1'b0, 8'd3);
    wait_done();
    result_valid = 1'b0;
    check("a_pass", pass_count, 32'd1);
    check("a_status", {30'd0, last_status}, 32'd1);
    check("a_last_cycles", last_cycles, 32'd9);
    check("a_done", {31'd0, done}, 32'd1);
    check("a_test_case", test_case, 32'd1);
    enable = 1'b0;
    @(negedge clk);
    check("a_done_drop", {31'd0, done}, 32'd0);

    // single-round vector table
    for (int v = 0; v < 8; v++) begin
      num_tests = 32'd1;
      enable = 1'b1;
      wait_start(at, n);
      drive_resp(vecs[v].d, vecs[v].rise, vecs[v].dl, vecs[v].iter);
      wait_done();
      result_valid = 1'b0;
      check($sformatf("v%0d_status", v), {30'd0, last_status}, {30'd0, vecs[v].st});
      check($sformatf("v%0d_last_cycles", v), last_cycles, vecs[v].lc);
      check($sformatf("v%0d_pass", v), pass_count, vecs[v].p);
      check($sformatf("v%0d_fail", v), fail_count, vecs[v].f);
      check($sformatf("v%0d_timeout", v), timeout_count, vecs[v].t);
      check($sformatf("v%0d_test_case", v), test_case, 32'd1);
      check($sformatf("v%0d_busy", v), {31'd0, busy}, 32'd0);
      enable = 1'b0;
      @(negedge clk);
    end

    // three passing rounds: spacing 5+1+GAP+1 and no auto-restart in DONE
    p0 = pulse_cnt;
    num_tests = 32'd3;
    enable = 1'b1;
    prev = 0;
    for (int r = 0; r < 3; r++) begin
      wait_start(at, n);
      if (r > 0) check($sformatf("b_spacing%0d", r), at - prev, 5 + 1 + GAP + 1);
      prev = at;
      repeat (5) @(negedge clk);
      iteration_counter = 8'd3;
      result_valid = 1'b1;
      repeat (2) @(negedge clk);
      result_valid = 1'b0;
    end
    wait_done();
    check("b_test_case", test_case, 32'd3);
    check("b_pass", pass_count, 32'd3);
    check("b_fail", fail_count, 32'd0);
    repeat (30) @(negedge clk);
    check("b_pulses", pulse_cnt - p0, 32'd3);
    check("b_done_held", {31'd0, done}, 32'd1);
    enable = 1'b0;
    @(negedge clk);
    check("b_done_drop", {31'd0, done}, 32'd0);

    // result_valid held high into round 2: no spurious pass, later fresh edge fails
    num_tests = 32'd2;
    enable = 1'b1;
    wait_start(at, n);
    repeat (4) @(negedge clk);
    iteration_counter = 8'd3;
    result_valid = 1'b1;
    wait_start(at, n);
    check("c_r1_pass", pass_count, 32'd1);
    repeat (6) @(negedge clk);
    check("c_still_busy", {31'd0, busy}, 32'd1);
    check("c_no_spurious", pass_count, 32'd1);
    result_valid = 1'b0;
    repeat (2) @(negedge clk);
    iteration_counter = 8'(MAXI + 1);
    result_valid = 1'b1;
    wait_done();
    result_valid = 1'b0;
    check("c_pass", pass_count, 32'd1);
    check("c_fail", fail_count, 32'd1);
    check("c_status", {30'd0, last_status}, 32'd2);
    check("c_last_cycles", last_cycles, 32'd7);
    check("c_test_case", test_case, 32'd2);
    enable = 1'b0;
    @(negedge clk);

    // timeout round, then next round after the gap
    num_tests = 32'd2;
    enable = 1'b1;
    wait_start(at, n);
    prev = at;
    wait_start(at, n);
    check("d_spacing", at - prev, TO + 2 + GAP);
    drive_resp(3, 1'b1, 1'b0, 8'd3);
    wait_done();
    result_valid = 1'b0;
    check("d_timeout", timeout_count, 32'd1);
    check("d_fail", fail_count, 32'd1);
    check("d_pass", pass_count, 32'd1);
    check("d_status", {30'd0, last_status}, 32'd1);
    check("d_last_cycles", last_cycles, 32'd2);
    enable = 1'b0;
    @(negedge clk);

    // num_tests == 0 goes straight to DONE
    p0 = pulse_cnt;
    num_tests = 32'd0;
    enable = 1'b1;
    repeat (3) @(negedge clk);
    check("f_done", {31'd0, done}, 32'd1);
    check("f_busy", {31'd0, busy}, 32'd0);
    check("f_pulses", pulse_cnt - p0, 32'd0);
    enable = 1'b0;
    @(negedge clk);
    check("f_done_drop", {31'd0, done}, 32'd0);

    // reset in WAIT of round 2 of 5, then full warmup and an enable-drop round
    num_tests = 32'd5;
    enable = 1'b1;
    wait_start(at, n);
    drive_resp(3, 1'b1, 1'b0, 8'd3);
    @(negedge clk);
    result_valid = 1'b0;
    wait_start(at, n);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("e_test_case", test_case, 32'd0);
    check("e_pass", pass_count, 32'd0);
    check("e_busy", {31'd0, busy}, 32'd0);
    check("e_cycle_counter", cycle_counter, 32'd0);
    check("e_state", {29'd0, state_o}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    wait_start(at, n);
    check("e_rewarm_latency", n, RT + 2);
    enable = 1'b0;
    wait_done();
    check("e_test_case_after", test_case, 32'd1);
    check("e_timeout", timeout_count, 32'd1);
    check("e_status", {30'd0, last_status}, 32'd3);
    @(negedge clk);
    check("e_done_drop", {31'd0, done}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
